// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: per-channel synchronizer, debounce FSM, press/release pulses.
// Optional auto-repeat of press pulses while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   in,
    output logic [N_BTN-1:0]   press,
    output logic [N_BTN-1:0]   released,
    output logic [N_BTN-1:0]   level,
    output logic               any_press,
    output logic [2*N_BTN-1:0] dbg_state
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (N_BTN < 1 || N_BTN > 16 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("button_conditioner: parameter out of range");
    end

    logic [N_BTN-1:0] sync_q [SYNC_STAGES];
    logic [N_BTN-1:0] s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [1:0]    state;
        logic [CW-1:0] cnt;
        logic          press_q;
        logic          release_q;

`ifdef BTN_AUTOREPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RCW  = $clog2(RMAX + 1);
        logic [RCW-1:0] rcnt;
        logic [RCW-1:0] rcnt_inc;
        logic           rep_phase;
        assign rcnt_inc = rcnt + RCW'(1);
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state     <= IDLE;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rcnt      <= '0;
                rep_phase <= 1'b0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    IDLE: begin
`ifdef BTN_AUTOREPEAT_EN
                        rcnt      <= '0;
                        rep_phase <= 1'b0;
`endif
                        if (s[i]) begin
                            state <= PRESS_WAIT;
                            cnt   <= CW'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s[i]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= HELD;
                            cnt     <= '0;
                            press_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rcnt      <= '0;
                            rep_phase <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!s[i]) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CW'(1);
                        end
`ifdef BTN_AUTOREPEAT_EN
                        // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
                        else begin
                            rcnt <= rcnt_inc;
                            if (rcnt_inc == (rep_phase ? RCW'(REPEAT_PERIOD) : RCW'(REPEAT_DELAY))) begin
                                press_q   <= 1'b1;
                                rcnt      <= '0;
                                rep_phase <= 1'b1;
                            end
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (s[i]) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign press[i]           = press_q;
        assign released[i]        = release_q;
        assign level[i]           = state[1];
        assign dbg_state[2*i +: 2] = state;
    end

    assign any_press = |press;

endmodule
